uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one tx UART transmitter among N_REQ byte producers (core, debug, status).
//  Uses round-robin arbitration and latches the granted byte. Pulses tx begin_flag
//  and holds tx data stable for the whole frame. Sits between requesters and tx.
// PARAMETERS
//  N_REQ         4    number of requesters, 2..8
//  BUSY_TIMEOUT  16   cycles to wait for tx_busy to rise after launch (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  reset_n    in   1        asynchronous reset, active-low
//  enable     in   1        global transmit enable, forwarded to tx.tx_en
//  req        in   N_REQ    per-requester level request; hold until ack
//  req_data   in   8*N_REQ  byte i at [8*i +: 8]
//  ack        out  N_REQ    one-cycle pulse: byte i latched, requester may drop/change
//  tx_en      out  1        = enable (combinational)
//  tx_begin   out  1        registered one-cycle start pulse to tx.begin_flag
//  tx_data    out  8        latched byte to tx.data; stable from grant to end of frame
//  tx_busy    in   1        tx.busy_flag
//  grant_id   out  clog2(N) index of last granted requester
//  active     out  1        high in any state other than IDLE
//  err        out  1        sticky launch-timeout flag (0 without UART_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; ack=0; tx_begin=0; tx_data=8'h00; grant_id=0; err=0.
//   - RR pointer last=N_REQ-1, so requester 0 wins first.
//  FSM, 2-bit, registered:
//   IDLE      : move only if enable & |req & !tx_busy. Winner w = first set req scanning
//               last+1, last+2, ... mod N_REQ. Then tx_data<=req_data[w], grant_id<=w,
//               last<=w, ack[w]<=1 for one cycle -> LAUNCH.
//   LAUNCH    : tx_begin=1 for exactly this cycle -> WAIT_BUSY.
//   WAIT_BUSY : tx_busy=1 -> SEND; else stay.
//   SEND      : tx_busy=0 -> IDLE; tx_data held throughout.
//  Timing and rules:
//   - Grant to tx_begin is 1 cycle. tx_busy rises the cycle after tx_begin. Min gap
//     between grants is 10 bit times + 3 cycles; no back-to-back chaining.
//   - Only one ack bit is ever set. No ack while state != IDLE.
//   - A req dropped before ack is simply skipped. A req held after ack is a new byte.
//   - enable falling mid-frame: the current frame completes and no new grant is made.
//     The tx module ignores tx_en once started.
//   - tx_busy already high in IDLE (foreign/in-flight frame): no grant until it is low.
//   - reset_n low mid-frame: immediate return to reset values. The tx module is reset
//     by the same net.
// CONFIGURATION
//  Macro UART_ARB_TIMEOUT_EN.
//   Defined: an 8-bit counter clears on entry to WAIT_BUSY and increments each cycle
//   there. At count == BUSY_TIMEOUT-1 without tx_busy: err<=1 (sticky until reset)
//   and state -> IDLE. The byte is dropped; ack was already given.
//   Undefined: WAIT_BUSY waits indefinitely, err tied 0, no counter.
// STRUCTURE
//  Package uart_arb_pkg:
//   - state localparams ST_IDLE=2'b00, ST_LAUNCH=2'b01, ST_WAIT=2'b11, ST_SEND=2'b10.
//   - function clog2 for the grant_id width.
//  Sub-module rr_pick: combinational, (req, last) -> (valid, winner index).
//  Rotate-and-priority-encode implementation. Reused by other arbiters.
// TESTING  (bench pairs with tx: CLK_FREQ=8, BAUD_RATE=1 -> 8 clk per bit)
//  1. req=4'b0001, data0=8'hA5, enable=1:
//     ack[0] one cycle; tx_begin one cycle later; line carries start,1,0,1,0,0,1,0,1,stop;
//     active falls after ~80 clk.
//  2. req=4'b1111 held for 8 frames: grant order 0,1,2,3,0,1,2,3; each ack once per frame.
//  3. req0 and req2 both held, grant_id=0 done: next grant is 2, then 0.
//     Requester 1 never acked.
//  4. enable=0 with req=4'b0010: no ack, no tx_begin for 100 clk.
//     Raise enable: ack[1] on the next cycle.
//  5. reset_n=0 during bit 3 of a frame: ack=0, tx_begin=0, tx_data=0, active=0 at once.
//     After release, req0 is granted first.
//  6. UART_ARB_TIMEOUT_EN with a bench-held tx_busy=0 stub: err=1 exactly 16 cycles
//     after LAUNCH; state IDLE; err stays 1 until reset.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART transmit arbiter.
//   state_t : 2-bit FSM encoding (IDLE=00, LAUNCH=01, WAIT=11, SEND=10)
//   clog2() : index width for a requester count (minimum 1 bit)
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b11,
        ST_SEND   = 2'b10
    } state_t;

    // Constant-bounded loop so it elaborates in any tool.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The request vector is rotated so that
// the requester after 'last' sits at bit 0, then priority-encoded; the offset
// found is mapped back to an absolute index.
// Ports:
//   req    in  [N-1:0]   request bits
//   last   in  [IW-1:0]  index granted most recently
//   valid  out           any request present
//   winner out [IW-1:0]  next requester in round-robin order (0 if !valid)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] winner
);

    logic [N-1:0] rot;
    int           off;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a signal unassigned and infers a latch.
        rot    = '0;
        off    = 0;
        valid  = |req;
        winner = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = req[(int'(last) + 1 + j) % N];
        end
        // Scan downward so the lowest set offset is the one left standing.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        if (valid) winner = IW'((int'(last) + 1 + off) % N);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte producers. A round-robin winner
// is acked and its byte latched; one cycle later tx_begin pulses, and tx_data
// is held until the transmitter drops tx_busy.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- abandon a launch (and set the
// sticky err flag) if tx_busy has not risen within BUSY_TIMEOUT cycles.
// Ports:
//   clk       in   system clock, posedge
//   reset_n   in   asynchronous reset, active-low
//   enable    in   global transmit enable (forwarded as tx_en)
//   req       in   [N_REQ-1:0] level requests, held until ack
//   req_data  in   [8*N_REQ-1:0] byte i at [8*i +: 8]
//   ack       out  [N_REQ-1:0] one-cycle pulse, byte latched
//   tx_en     out  = enable
//   tx_begin  out  one-cycle start pulse to the transmitter
//   tx_data   out  [7:0] latched byte
//   tx_busy   in   transmitter busy
//   grant_id  out  index of last granted requester
//   active    out  FSM not idle
//   err       out  sticky launch-timeout flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      tx_en,
    output logic                      tx_begin,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [clog2(N_REQ)-1:0]   grant_id,
    output logic                      active,
    output logic                      err
);

    localparam int IW = clog2(N_REQ);

    state_t          state, state_nxt;
    logic [IW-1:0]   last;
    logic            pick_valid;
    logic [IW-1:0]   pick_winner;
    logic            grant;

`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0]      cnt;
    logic            timeout;
`endif

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req    (req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign tx_en  = enable;
    assign active = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // A busy transmitter in IDLE means someone else's frame is on
                // the line; wait for it rather than stacking a start pulse.
                if (enable && pick_valid && !tx_busy) begin
                    grant     = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (tx_busy) begin
                    state_nxt = ST_SEND;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt == 8'(BUSY_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_SEND: if (!tx_busy) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack      <= '0;
            tx_begin <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            last     <= IW'(N_REQ - 1);
        end else begin
            ack      <= '0;
            tx_begin <= (state == ST_LAUNCH);
            if (grant) begin
                ack[pick_winner] <= 1'b1;
                tx_data          <= req_data[DATA_W*pick_winner +: DATA_W];
                grant_id         <= pick_winner;
                last             <= pick_winner;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state_nxt == ST_WAIT && state != ST_WAIT) cnt <= '0;
            else if (state == ST_WAIT)                    cnt <= cnt + 8'd1;
            if (timeout) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
